// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches to instruction
// memory, buffers the in-order responses in a small FIFO and presents the head
// entry to decode. A redirect flushes the FIFO and marks every in-flight
// response as stale so it is dropped on return.
module prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        branched_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        self_valid_o,
  input  logic        next_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Architectural state
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [1:0]       outstanding_reg, outstanding_next;
  logic [1:0]       discard_reg, discard_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

  // FIFO storage (PC and instruction word per entry)
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  // Handshake decodes
  logic             grant;
  logic             push;
  logic             pop;
  logic             has_head;
  logic             credit_ok;
  logic [CNT_W:0]   occupancy;
  logic [1:0]       outstanding_acc;

  // Redirect targets are word aligned; the low PC bits are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, pc_i[1:0]};

  // Output and handshake decode; reset forces the visible outputs quiet.
  always_comb begin
    has_head     = (count_reg != '0);
    // Buffered entries plus in-flight requests must never exceed the FIFO size,
    // so every response that comes back is guaranteed a free slot.
    occupancy    = {1'b0, count_reg} + (CNT_W+1)'(outstanding_reg);
    credit_ok    = (occupancy < (CNT_W+1)'(DEPTH));
    mem_req_o    = !reset && run && !branched_i && (outstanding_reg < 2'd2) && credit_ok;
    mem_addr_o   = fetch_pc_reg;
    self_valid_o = !reset && has_head && !stall_i;
    pc_o         = (!reset && has_head) ? pc_mem[rd_ptr_reg]    : 32'd0;
    instr_o      = (!reset && has_head) ? instr_mem[rd_ptr_reg] : 32'd0;
    grant        = mem_req_o && mem_gnt_i;
    push         = mem_rvalid_i && (discard_reg == 2'd0) && !branched_i;
    pop          = self_valid_o && next_ready_i && !branched_i;
    // In-flight count once this cycle's grant and response are accounted for.
    outstanding_acc = outstanding_reg + {1'b0, grant} - {1'b0, mem_rvalid_i};
  end

  // Next-state computation; a redirect overrides the normal fetch/FIFO update.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    count_next       = count_reg + CNT_W'(push) - CNT_W'(pop);
    outstanding_next = outstanding_acc;
    discard_next     = discard_reg;
    rd_ptr_next      = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    wr_ptr_next      = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;

    if (grant) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
    if (push) begin
      resp_pc_next = resp_pc_reg + 32'd4;
    end
    if (mem_rvalid_i && (discard_reg != 2'd0)) begin
      discard_next = discard_reg - 2'd1;
    end

    if (branched_i) begin
      // Everything still in flight belongs to the old path and must be dropped.
      fetch_pc_next = {pc_i[31:2], 2'b00};
      resp_pc_next  = {pc_i[31:2], 2'b00};
      discard_next  = outstanding_acc;
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= 2'd0;
      discard_reg     <= 2'd0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // FIFO storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
      instr_mem[wr_ptr_reg] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of fetched entries.
module tb_prefetch_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] MAIN_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, run, branched_i, stall_i, next_ready_i;
  logic [31:0] pc_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, self_valid_o;
  logic [31:0] mem_addr_o, mem_rdata_i, pc_o, instr_o;

  logic        u2_reset, u2_run, u2_branched, u2_stall, u2_ready, u2_gnt, u2_rvalid;
  logic [31:0] u2_pc_in, u2_rdata, u2_addr, u2_pc, u2_instr;
  logic        u2_req, u2_valid;

  always #5 clk = ~clk;

  prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(MAIN_PC)) dut (
    .clk(clk), .reset(reset), .run(run), .branched_i(branched_i), .pc_i(pc_i),
    .stall_i(stall_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .self_valid_o(self_valid_o), .next_ready_i(next_ready_i), .pc_o(pc_o), .instr_o(instr_o)
  );

  prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(u2_reset), .run(u2_run), .branched_i(u2_branched), .pc_i(u2_pc_in),
    .stall_i(u2_stall), .mem_req_o(u2_req), .mem_addr_o(u2_addr),
    .mem_gnt_i(u2_gnt), .mem_rvalid_i(u2_rvalid), .mem_rdata_i(u2_rdata),
    .self_valid_o(u2_valid), .next_ready_i(u2_ready), .pc_o(u2_pc), .instr_o(u2_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  // Reference model: buffered PCs, in-flight requests tagged by redirect epoch.
  logic [31:0] q[$];
  req_t        infl[$];
  int          epoch = 0;
  logic [31:0] fetch_addr = MAIN_PC;
  int          cyc = 0;
  int          rv_pct = 100;
  int          lat_extra = 0;
  logic [31:0] pop_log[$];

  logic        u2_pend = 1'b0;
  logic [31:0] u2_pend_addr = 32'd0;
  logic [31:0] u2_log[$];

  logic        last_req, last_valid;
  logic [31:0] last_pc, last_instr;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory responses, compare outputs, advance the model.
  task automatic tick();
    logic        resp, exp_req, exp_valid, grant, pop;
    logic [31:0] exp_pc, exp_instr;
    req_t        e;
    resp = 1'b0;
    if (!reset && infl.size() > 0 && infl[0].due <= cyc && ($urandom_range(99, 0) < rv_pct))
      resp = 1'b1;
    mem_rvalid_i = resp;
    mem_rdata_i  = resp ? mem_word(infl[0].addr) : $urandom();
    u2_rvalid    = u2_pend;
    u2_rdata     = mem_word(u2_pend_addr);
    #1;
    exp_req   = !reset && run && !branched_i && infl.size() < 2 && (q.size() + infl.size()) < DEPTH;
    exp_valid = !reset && q.size() > 0 && !stall_i;
    exp_pc    = (!reset && q.size() > 0) ? q[0] : 32'd0;
    exp_instr = (!reset && q.size() > 0) ? mem_word(q[0]) : 32'd0;
    check("mem_req", {31'd0, mem_req_o}, {31'd0, exp_req});
    if (exp_req) check("mem_addr", mem_addr_o, fetch_addr);
    check("self_valid", {31'd0, self_valid_o}, {31'd0, exp_valid});
    check("pc_o", pc_o, exp_pc);
    check("instr_o", instr_o, exp_instr);
    last_req = mem_req_o; last_valid = self_valid_o; last_pc = pc_o; last_instr = instr_o;
    grant = exp_req && mem_gnt_i;
    pop   = exp_valid && next_ready_i && !branched_i;
    if (pop) begin
      $display("cycle %0d pop pc=%h instr=%h", cyc, pc_o, instr_o);
      pop_log.push_back(pc_o);
    end
    if (!u2_reset && u2_valid && u2_log.size() < 3) begin
      $display("cycle %0d wrap-dut pop pc=%h instr=%h", cyc, u2_pc, u2_instr);
      check("wrap_instr", u2_instr, mem_word(u2_pc));
      u2_log.push_back(u2_pc);
    end
    @(posedge clk);
    if (reset) begin
      q.delete(); infl.delete(); fetch_addr = MAIN_PC;
    end else begin
      if (resp) begin
        e = infl.pop_front();
        if (!branched_i && e.epoch == epoch) q.push_back(e.addr);
      end
      if (pop) void'(q.pop_front());
      if (grant) begin
        infl.push_back('{fetch_addr, epoch, cyc + 1 + int'($urandom_range(lat_extra, 0))});
        fetch_addr = fetch_addr + 32'd4;
      end
      if (branched_i) begin
        q.delete(); epoch++; fetch_addr = {pc_i[31:2], 2'b00};
      end
    end
    if (u2_reset) u2_pend = 1'b0;
    else begin u2_pend = u2_req; u2_pend_addr = u2_addr; end
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; branched_i = 1'b0;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; branched_i = 1'b0; pc_i = 32'd0; stall_i = 1'b0;
    next_ready_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    u2_reset = 1'b1; u2_run = 1'b1; u2_branched = 1'b0; u2_pc_in = 32'd0; u2_stall = 1'b0;
    u2_ready = 1'b1; u2_gnt = 1'b1; u2_rvalid = 1'b0; u2_rdata = 32'd0;

    // Reset state
    run = 1'b1; next_ready_i = 1'b1;
    tick();
    check("reset_req", {31'd0, last_req}, 32'd0);
    check("reset_valid", {31'd0, last_valid}, 32'd0);
    check("reset_pc", last_pc, 32'd0);
    check("reset_instr", last_instr, 32'd0);
    tick();
    reset = 1'b0; u2_reset = 1'b0;

    // Streaming: one instruction per cycle after a two-cycle fill
    pop_log.delete();
    ticks(10);
    check("stream_count", pop_log.size(), 32'd8);
    check("stream_pc0", pop_log[0], 32'h0);
    check("stream_pc1", pop_log[1], 32'h4);
    check("stream_pc2", pop_log[2], 32'h8);

    // Back-pressure fills the buffer and stops requests, then drains in order
    next_ready_i = 1'b0;
    ticks(8);
    check("full_req_off", {31'd0, last_req}, 32'd0);
    check("full_valid", {31'd0, last_valid}, 32'd1);
    run = 1'b0; next_ready_i = 1'b1; pop_log.delete();
    ticks(4);
    check("drain_count", pop_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("drain_order", pop_log[i], 32'h20 + 32'(4 * i));
    tick();
    check("drain_empty", {31'd0, last_valid}, 32'd0);

    // Redirect with two requests in flight drops both responses
    run = 1'b1; do_reset();
    branched_i = 1'b1; pc_i = 32'h10; tick(); branched_i = 1'b0;
    rv_pct = 0; ticks(3);
    check("two_outstanding_req_off", {31'd0, last_req}, 32'd0);
    branched_i = 1'b1; pc_i = 32'h200; tick(); branched_i = 1'b0;
    rv_pct = 100; pop_log.delete();
    ticks(8);
    check("redirect_first_pc", pop_log[0], 32'h200);

    // Redirect coinciding with a response; unaligned target is word aligned
    do_reset();
    branched_i = 1'b1; pc_i = 32'h10; tick(); branched_i = 1'b0;
    rv_pct = 0; ticks(3);
    rv_pct = 100; branched_i = 1'b1; pc_i = 32'h103; pop_log.delete();
    tick(); branched_i = 1'b0;
    ticks(8);
    check("redirect_rvalid_pc", pop_log[0], 32'h100);

    // Stall hides two buffered entries; release pops them in order
    do_reset();
    next_ready_i = 1'b0; ticks(2);
    run = 1'b0; ticks(2);
    stall_i = 1'b1; next_ready_i = 1'b1; pop_log.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, last_valid}, 32'd0);
    end
    check("stall_no_pop", pop_log.size(), 32'd0);
    stall_i = 1'b0; ticks(3);
    check("stall_release_count", pop_log.size(), 32'd2);
    check("stall_release_pc0", pop_log[0], 32'h0);
    check("stall_release_pc1", pop_log[1], 32'h4);

    // Address wrap through redirect
    run = 1'b1; do_reset();
    branched_i = 1'b1; pc_i = 32'hFFFF_FFF9; pop_log.delete(); tick(); branched_i = 1'b0;
    ticks(8);
    check("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
    check("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
    check("wrap_pc2", pop_log[2], 32'h0000_0000);

    // Non-zero reset PC instance
    check("resetpc_count", u2_log.size(), 32'd3);
    check("resetpc_pc0", u2_log[0], 32'hFFFF_FFF8);
    check("resetpc_pc1", u2_log[1], 32'hFFFF_FFFC);
    check("resetpc_pc2", u2_log[2], 32'h0000_0000);

    // Random traffic against the model
    rv_pct = 70; lat_extra = 3;
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(999, 0) < 3);
      run          = ($urandom_range(99, 0) < 80);
      branched_i   = ($urandom_range(99, 0) < 4);
      pc_i         = ($urandom_range(1, 0) == 0) ? $urandom() : (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)));
      stall_i      = ($urandom_range(99, 0) < 20);
      next_ready_i = ($urandom_range(99, 0) < 70);
      mem_gnt_i    = ($urandom_range(99, 0) < 70);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prefetch_buffer.md
PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: instruction FIFO entries, power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 run  input  1  high permits new memory requests; low blocks new requests only.
REQ-006 branched_i  input  1  redirect strobe from control; flushes the buffer.
REQ-007 pc_i  input  32  redirect target; sampled when branched_i=1.
REQ-008 stall_i  input  1  control stall; holds the decode-side output.
REQ-009 mem_req_o  output  1  instruction memory request.
REQ-010 mem_addr_o  output  32  request word address; bits [1:0] always 0.
REQ-011 mem_gnt_i  input  1  request accepted this cycle.
REQ-012 mem_rvalid_i  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-013 mem_rdata_i  input  32  instruction word.
REQ-014 self_valid_o  output  1  head entry presented to decode.
REQ-015 next_ready_i  input  1  decode accepts the head entry.
REQ-016 pc_o  output  32  PC of head entry.
REQ-017 instr_o  output  32  instruction word of head entry.

Function
REQ-018 State: fetch_pc (next request address), resp_pc (PC of next accepted response), FIFO count, outstanding counter (0..2), discard counter (0..2).
REQ-019 mem_req_o = run && !branched_i && outstanding<2 && (count+outstanding)<DEPTH; combinational.
REQ-020 mem_addr_o = fetch_pc; on mem_req_o && mem_gnt_i: fetch_pc += 4, outstanding += 1.
REQ-021 A request not yet granted may be withdrawn or change address (run low, redirect); no hold requirement.
REQ-022 On mem_rvalid_i: outstanding -= 1; if discard>0, discard -= 1 and data dropped; else push {resp_pc, mem_rdata_i} and resp_pc += 4.
REQ-023 Credit rule of REQ-019 guarantees no push into a full FIFO; an overflow is a design error, not handled.
REQ-024 self_valid_o = (count>0) && !stall_i; pc_o/instr_o driven from head whenever count>0, else 0.
REQ-025 Pop when self_valid_o && next_ready_i; simultaneous push and pop leaves count unchanged; head-to-output latency 0 cycles.
REQ-026 First instruction reaches output the cycle after its mem_rvalid_i (registered FIFO, no bypass).
REQ-027 Redirect (branched_i=1): FIFO emptied, fetch_pc and resp_pc <= {pc_i[31:2],2'b00}, discard <= outstanding after this cycle's grant/response accounting, no pop, no push.
REQ-028 Redirect coinciding with mem_rvalid_i: that response is dropped and counted out of outstanding, not of discard.
REQ-029 Redirect with discard already nonzero: discard = new outstanding value (all in-flight responses are stale).
REQ-030 run low: outstanding requests complete and are buffered normally; output handshake unaffected.
REQ-031 fetch_pc and resp_pc wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-032 On reset: fetch_pc=resp_pc=RESET_PC, count=0, outstanding=0, discard=0; mem_req_o=0, self_valid_o=0, pc_o=0, instr_o=0 in the cycle reset is high.
REQ-033 Reset mid-operation abandons in-flight requests; memory side must be reset together (responses after reset are not discarded).
REQ-034 Reset has priority over branched_i, run and all handshakes.

Verification
REQ-035 Reset release, run=1, gnt every cycle, 1-cycle rvalid, ready=1: pc_o sequence 0x0,0x4,0x8 with instr_o matching memory, one per cycle after fill.
REQ-036 next_ready_i=0, gnt always: exactly 4 entries buffered, mem_req_o drops to 0, outstanding=0; ready=1 drains 4 in 4 cycles in order.
REQ-037 Two requests outstanding (0x10,0x14), branched_i with pc_i=0x200: both responses dropped, next pc_o=0x200.
REQ-038 branched_i in same cycle as rvalid of 0x10 with 0x14 outstanding, pc_i=0x103: 0x10 and 0x14 dropped, first output pc_o=0x100.
REQ-039 stall_i=1 with 2 entries and ready=1: self_valid_o=0, no pop; stall release pops in order.
REQ-040 RESET_PC=32'hFFFF_FFF8: outputs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
